// File: rtl/tlc_pkg.sv
// Shared definitions for the multi-approach traffic-light controller.
//   tlc_state_t : FSM state codes (3 bits; codes 6 and 7 are unused)
//   SEL_*       : interval select codes used by prog_sel and the interval bank
//   LED_*       : {R,Y,G} lamp encodings for one signal group
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    ALL_RED = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_Y  = 3'd4,
    WALK    = 3'd5
  } tlc_state_t;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_ARED = 2'd3;

  localparam logic [2:0] LED_RED = 3'b100;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_GRN = 3'b001;

endpackage

// File: rtl/tlc_interval_timer.sv
// Down-counting interval timer in timebase ticks.
//   clk, rst   : clock, asynchronous active-high reset (count -> RST_VAL)
//   tick       : timebase strobe; count decrements only on tick
//   load/value : load a new interval (takes priority over tick); 0 loads as 1
//   remaining  : ticks left in the current interval
//   expired    : tick arriving while remaining == 1 (last tick of the interval)
module tlc_interval_timer #(
  parameter int TW = 8,
  parameter logic [TW-1:0] RST_VAL = TW'(12)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic [TW-1:0] remaining,
  output logic          expired
);

  // The count never rests at 0: a zero interval behaves like one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= (RST_VAL == '0) ? TW'(1) : RST_VAL;
    end else if (load) begin
      remaining <= (value == '0) ? TW'(1) : value;
    end else if (tick && remaining > TW'(1)) begin
      remaining <= remaining - TW'(1);
    end
  end

  assign expired = tick && (remaining == TW'(1));

endmodule

// File: rtl/tlc_multi_approach_ctrl.sv
// Traffic-light controller: one main road plus N_APP side approaches served
// round-robin on demand, with walk phase, all-red clearance, programmable
// intervals and rest-in-main-green.
//   clk, rst           : clock, asynchronous active-high reset
//   tick               : timebase strobe
//   prog/prog_sel/val  : write an interval, then force MAIN_G with 2*BASE
//   sensor             : per-approach vehicle presence
//   walk_req           : walk request (latched until served)
//   main_led/side_led  : {R,Y,G} lamps, approach i at side_led[3i+2:3i]
//   walk, walk_ack     : walk lamp, 1-cycle pulse on WALK entry
//   state_o, remaining : debug state code, ticks left in current interval
module tlc_multi_approach_ctrl
  import tlc_pkg::*;
#(
  parameter int N_APP    = 2,
  parameter int TW       = 8,
  parameter int T_BASE_D = 6,
  parameter int T_EXT_D  = 3,
  parameter int T_YEL_D  = 2,
  parameter int T_ARED_D = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               prog,
  input  logic [1:0]         prog_sel,
  input  logic [TW-1:0]      prog_val,
  input  logic [N_APP-1:0]   sensor,
  input  logic               walk_req,
  output logic [2:0]         main_led,
  output logic [3*N_APP-1:0] side_led,
  output logic               walk,
  output logic               walk_ack,
  output logic [2:0]         state_o,
  output logic [TW-1:0]      remaining
);

  localparam int AW = (N_APP > 1) ? $clog2(N_APP) : 1;

  // 2*b, saturating at all-ones.
  function automatic logic [TW-1:0] sat2(input logic [TW-1:0] b);
    logic [TW:0] d;
    d = {b, 1'b0};
    return d[TW] ? {TW{1'b1}} : d[TW-1:0];
  endfunction

  // First approach with a vehicle, searching upward from p with wrap.
  // Returns p when nobody is waiting; the caller re-checks the sensor.
  function automatic logic [AW-1:0] rr_pick(input logic [N_APP-1:0] s,
                                            input logic [AW-1:0]    p);
    logic [AW-1:0] r;
    logic          found;
    int            idx;
    r     = p;
    found = 1'b0;
    for (int k = 0; k < N_APP; k++) begin
      idx = (int'(p) + k) % N_APP;
      if (!found && s[AW'(idx)]) begin
        r     = AW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  localparam logic [TW-1:0] T_RST = sat2(TW'(T_BASE_D));

  tlc_state_t    state, state_nxt, dst, dst_nxt;
  logic [AW-1:0] cur, cur_nxt, rr_ptr, rr_nxt;
  logic          ext_used, ext_nxt, walk_lat, enter_walk;
  logic [TW-1:0] ival [4];
  logic          ld, expired;
  logic [TW-1:0] ld_val;
  logic [2:0]         main_nxt;
  logic [3*N_APP-1:0] side_nxt;
  logic               walk_nxt;

  tlc_interval_timer #(.TW(TW), .RST_VAL(T_RST)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .load      (ld),
    .value     (ld_val),
    .remaining (remaining),
    .expired   (expired)
  );

  // Next-state logic. prog overrides any expiry in the same cycle; illegal
  // state codes recover to MAIN_G at once without waiting for expiry.
  always_comb begin
    state_nxt  = state;
    dst_nxt    = dst;
    cur_nxt    = cur;
    rr_nxt     = rr_ptr;
    ext_nxt    = ext_used;
    ld         = 1'b0;
    ld_val     = ival[SEL_BASE];
    enter_walk = 1'b0;
    if (prog) begin
      state_nxt = MAIN_G;
      ld        = 1'b1;
      ld_val    = sat2((prog_sel == SEL_BASE) ? prog_val : ival[SEL_BASE]);
      ext_nxt   = 1'b0;
    end else begin
      case (state)
        MAIN_G: if (expired) begin
          ld = 1'b1;
          if ((|sensor) || walk_lat) begin
            state_nxt = MAIN_Y;
            ld_val    = ival[SEL_YEL];
          end
        end
        MAIN_Y: if (expired) begin
          ld        = 1'b1;
          ld_val    = ival[SEL_ARED];
          state_nxt = ALL_RED;
          dst_nxt   = walk_lat ? WALK : SIDE_G;
          cur_nxt   = rr_pick(sensor, rr_ptr);
        end
        ALL_RED: if (expired) begin
          ld = 1'b1;
          if (dst == WALK) begin
            state_nxt  = WALK;
            ld_val     = ival[SEL_EXT];
            enter_walk = 1'b1;
          end else if (dst == SIDE_G && sensor[cur]) begin
            state_nxt = SIDE_G;
            ext_nxt   = 1'b0;
          end else begin
            state_nxt = MAIN_G;
          end
        end
        SIDE_G: if (expired) begin
          ld = 1'b1;
          if (sensor[cur] && !ext_used) begin
            ld_val  = ival[SEL_EXT];
            ext_nxt = 1'b1;
          end else begin
            state_nxt = SIDE_Y;
            ld_val    = ival[SEL_YEL];
            rr_nxt    = (int'(cur) + 1 >= N_APP) ? '0 : cur + AW'(1);
          end
        end
        SIDE_Y: if (expired) begin
          ld        = 1'b1;
          ld_val    = ival[SEL_ARED];
          state_nxt = ALL_RED;
          dst_nxt   = MAIN_G;
        end
        WALK: if (expired) begin
          ld        = 1'b1;
          ld_val    = ival[SEL_ARED];
          state_nxt = ALL_RED;
          dst_nxt   = (|sensor) ? SIDE_G : MAIN_G;
          cur_nxt   = rr_pick(sensor, rr_ptr);
        end
        default: begin
          state_nxt = MAIN_G;
          ld        = 1'b1;
        end
      endcase
    end
  end

  // Lamp decode from the next state so the registered lamps track the state.
  always_comb begin
    main_nxt = LED_RED;
    side_nxt = {N_APP{LED_RED}};
    walk_nxt = 1'b0;
    case (state_nxt)
      MAIN_G:  main_nxt = LED_GRN;
      MAIN_Y:  main_nxt = LED_YEL;
      SIDE_G:  side_nxt[int'(cur_nxt)*3 +: 3] = LED_GRN;
      SIDE_Y:  side_nxt[int'(cur_nxt)*3 +: 3] = LED_YEL;
      WALK:    walk_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MAIN_G;
      dst      <= MAIN_G;
      cur      <= '0;
      rr_ptr   <= '0;
      ext_used <= 1'b0;
      walk_lat <= 1'b0;
      ival[SEL_BASE] <= TW'(T_BASE_D);
      ival[SEL_EXT]  <= TW'(T_EXT_D);
      ival[SEL_YEL]  <= TW'(T_YEL_D);
      ival[SEL_ARED] <= TW'(T_ARED_D);
      main_led <= LED_GRN;
      side_led <= {N_APP{LED_RED}};
      walk     <= 1'b0;
      walk_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      dst      <= dst_nxt;
      cur      <= cur_nxt;
      rr_ptr   <= rr_nxt;
      ext_used <= ext_nxt;
      // A new request in the serving cycle survives the clear.
      walk_lat <= walk_req || (walk_lat && !enter_walk);
      if (prog) ival[prog_sel] <= prog_val;
      main_led <= main_nxt;
      side_led <= side_nxt;
      walk     <= walk_nxt;
      walk_ack <= enter_walk;
    end
  end

  assign state_o = state;

endmodule
